// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit hex 7-segment driver. A latched 32-bit word is scanned
// one digit per slot; new values take effect only at the end of a full frame.
module seg_scan_driver #(
    parameter int CLK_DIV  = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] din,
    input  logic        load,
    output logic [7:0]  SEG,
    output logic [7:0]  AN
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      pend_val;
    logic             pend_flag;
    logic [31:0]      disp_val;

    logic        tick;
    logic        frame_end;
    logic [3:0]  nib;
    logic [31:0] upper;
    logic        blank;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Digit idx is blank when it and every more significant nibble are zero.
    always_comb begin
        tick      = (cnt == CNT_MAX);
        frame_end = tick && (idx == 3'd7);
        nib       = disp_val[{idx, 2'b00} +: 4];
        upper     = disp_val >> {idx, 2'b00};
        blank     = BLANK_LZ && (idx != 3'd0) && (upper == 32'd0);
    end

    // load is a single-cycle strobe with no back-pressure: every asserted
    // cycle is accepted, and a later load in the same frame replaces an
    // earlier pending one.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt       <= '0;
            idx       <= 3'd0;
            pend_val  <= 32'd0;
            pend_flag <= 1'b0;
            disp_val  <= 32'd0;
            SEG       <= 8'hFF;
            AN        <= 8'hFF;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick)
                idx <= idx + 3'd1;

            if (load && frame_end) begin
                disp_val  <= din;
                pend_flag <= 1'b0;
            end else if (frame_end && pend_flag) begin
                disp_val  <= pend_val;
                pend_flag <= 1'b0;
            end else if (load) begin
                pend_val  <= din;
                pend_flag <= 1'b1;
            end

            AN  <= ~(8'b1 << idx);
            SEG <= blank ? 8'hFF : hex7(nib);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a CLK_DIV=4 instance for scan, commit,
// blanking and reset scenarios, plus a CLK_DIV=1 instance for the fast walk.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        load;
    logic [7:0]  seg;
    logic [7:0]  an;

    logic        rst1;
    logic [7:0]  seg1;
    logic [7:0]  an1;

    int n_checks;
    int n_fail;
    int e;

    logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    seg_scan_driver #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk (clk),
        .RST (rst),
        .din (din),
        .load(load),
        .SEG (seg),
        .AN  (an)
    );

    seg_scan_driver #(.CLK_DIV(1), .BLANK_LZ(1'b1)) dut1 (
        .clk (clk),
        .RST (rst1),
        .din (32'd0),
        .load(1'b0),
        .SEG (seg1),
        .AN  (an1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int t);
        while (e < t) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (seg !== 8'hFF || an !== 8'hFF) begin
                n_fail++;
                $display("FAIL reset_hold: SEG=%h AN=%h, required SEG=FF AN=FF", seg, an);
            end
        end
        rst = 1'b0;
        e = 0;
        step();
        n_checks++;
        if (an !== 8'hFE || seg !== 8'hC0) begin
            n_fail++;
            $display("FAIL first_edge: SEG=%h AN=%h, required SEG=C0 AN=FE", seg, an);
        end
        run_to(4);
        n_checks++;
        if (an !== 8'hFE) begin
            n_fail++;
            $display("FAIL slot0_hold: AN=%h, required FE", an);
        end
        step();
        n_checks++;
        if (an !== 8'hFD || seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL slot1_start: SEG=%h AN=%h, required SEG=FF AN=FD", seg, an);
        end
    endtask

    task automatic test_frame_commit();
        logic [7:0] exp_seg [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        logic [7:0] exp_old;
        din  = 32'h1234ABCD;
        load = 1'b1;
        step();
        load = 1'b0;
        // Rest of this frame must keep showing the old value 0.
        while (e < 32) begin
            step();
            exp_old = (((e - 1) / 4) % 8 == 0) ? 8'hC0 : 8'hFF;
            n_checks++;
            if (seg !== exp_old) begin
                n_fail++;
                $display("FAIL hold_old e=%0d: SEG=%h, required %h", e, seg, exp_old);
            end
        end
        for (int k = 0; k < 8; k++) begin
            run_to(33 + 4 * k);
            n_checks++;
            if (seg !== exp_seg[k] || an !== an_tab[k]) begin
                n_fail++;
                $display("FAIL sweep_1234ABCD d%0d: SEG=%h AN=%h, required SEG=%h AN=%h",
                         k, seg, an, exp_seg[k], an_tab[k]);
            end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] exp_f0 [8] = '{8'hC0, 8'h8E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] exp_z  [8] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_to(64);
        din  = 32'h0000_00F0;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            run_to(97 + 4 * k);
            n_checks++;
            if (seg !== exp_f0[k] || an !== an_tab[k]) begin
                n_fail++;
                $display("FAIL blank_F0 d%0d: SEG=%h AN=%h, required SEG=%h AN=%h",
                         k, seg, an, exp_f0[k], an_tab[k]);
            end
        end
        run_to(128);
        din  = 32'h0;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            run_to(161 + 4 * k);
            n_checks++;
            if (seg !== exp_z[k] || an !== an_tab[k]) begin
                n_fail++;
                $display("FAIL blank_zero d%0d: SEG=%h AN=%h, required SEG=%h AN=%h",
                         k, seg, an, exp_z[k], an_tab[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_to(192);
        din  = 32'h1111_1111;
        load = 1'b1;
        step();
        load = 1'b0;
        run_to(196);
        din  = 32'h2222_2222;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            run_to(225 + 4 * k);
            n_checks++;
            if (seg !== 8'hA4) begin
                n_fail++;
                $display("FAIL last_load_wins d%0d: SEG=%h, required A4", k, seg);
            end
        end
        // Load on the frame_end edge itself goes straight to the display.
        run_to(255);
        din  = 32'h5555_5555;
        load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (seg !== 8'hA4 || an !== 8'h7F) begin
            n_fail++;
            $display("FAIL frame_end_edge: SEG=%h AN=%h, required SEG=A4 AN=7F", seg, an);
        end
        for (int k = 0; k < 8; k++) begin
            run_to(257 + 4 * k);
            n_checks++;
            if (seg !== 8'h92 || an !== an_tab[k]) begin
                n_fail++;
                $display("FAIL load_at_frame_end d%0d: SEG=%h AN=%h, required SEG=92 AN=%h",
                         k, seg, an, an_tab[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_seg;
        run_to(290);
        din  = 32'h9999_9999;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (seg !== 8'hFF || an !== 8'hFF) begin
            n_fail++;
            $display("FAIL mid_reset: SEG=%h AN=%h, required SEG=FF AN=FF", seg, an);
        end
        rst = 1'b0;
        e = 0;
        step();
        n_checks++;
        if (seg !== 8'hC0 || an !== 8'hFE) begin
            n_fail++;
            $display("FAIL post_reset_edge: SEG=%h AN=%h, required SEG=C0 AN=FE", seg, an);
        end
        for (int k = 0; k < 8; k++) begin
            run_to(33 + 4 * k);
            exp_seg = (k == 0) ? 8'hC0 : 8'hFF;
            n_checks++;
            if (seg !== exp_seg || an !== an_tab[k]) begin
                n_fail++;
                $display("FAIL pending_dropped d%0d: SEG=%h AN=%h, required SEG=%h AN=%h",
                         k, seg, an, exp_seg, an_tab[k]);
            end
        end
    endtask

    task automatic test_div1_walk();
        rst1 = 1'b1;
        step();
        n_checks++;
        if (an1 !== 8'hFF) begin
            n_fail++;
            $display("FAIL div1_reset: AN=%h, required FF", an1);
        end
        rst1 = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            step();
            n_checks++;
            if (an1 !== an_tab[(i - 1) % 8]) begin
                n_fail++;
                $display("FAIL div1_walk c%0d: AN=%h, required %h", i, an1, an_tab[(i - 1) % 8]);
            end
            n_checks++;
            if ($countones(~an1) != 1) begin
                n_fail++;
                $display("FAIL div1_onehot c%0d: AN=%h, required exactly one low bit", i, an1);
            end
        end
        n_checks++;
        if (seg1 !== 8'hC0) begin
            n_fail++;
            $display("FAIL div1_seg: SEG=%h, required C0", seg1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        e        = 0;
        rst      = 1'b1;
        rst1     = 1'b1;
        din      = 32'd0;
        load     = 1'b0;
        test_reset();
        test_frame_commit();
        test_blanking();
        test_back_to_back();
        test_reset_mid_frame();
        test_div1_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
